// File: rtl/axi_timer_regs.sv
// axi_timer_regs
// Register-mapped timer/PWM peripheral fed by the AXI4-Lite slave's simple
// strobe interface. Provides a prescaled up-counter with period wrap, a
// one-shot mode, a compare-based PWM output and a level interrupt.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   wr_addr  word address for writes (4 bits)
//   wr_en    one-cycle write strobe
//   wr_data  write data (32 bits)
//   wr_strb  byte enables, bit n covers wr_data[8n+7:8n]
//   wr_ack   one-cycle write acknowledge, the cycle after wr_en
//   rd_addr  word address for reads (4 bits)
//   rd_en    one-cycle read strobe
//   rd_data  read data, valid while rd_ack is high, held otherwise
//   rd_ack   one-cycle read acknowledge, the cycle after rd_en
//   irq      level interrupt: OVF & IRQ_EN, registered
//   pwm_out  PWM output: EN & (COUNT < COMPARE), registered
//
// Register map (word address):
//   0 CTRL     [0] EN, [1] IRQ_EN, [2] ONESHOT
//   1 STATUS   [0] OVF, write-1-to-clear
//   2 PERIOD   32-bit
//   3 COUNT    32-bit, a write reloads the counter and clears the prescaler
//   4 COMPARE  32-bit
//   5 PRESCALE PRESC_BITS wide
//   6-15       reserved, read zero, writes acked and ignored

module axi_timer_regs #(
    parameter int          PRESC_BITS = 16,
    parameter logic [31:0] PERIOD_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        wr_ack,
    input  logic [3:0]  rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_ack,
    output logic        irq,
    output logic        pwm_out
);

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_PERIOD   = 4'd2;
    localparam logic [3:0] ADDR_COUNT    = 4'd3;
    localparam logic [3:0] ADDR_COMPARE  = 4'd4;
    localparam logic [3:0] ADDR_PRESCALE = 4'd5;

    logic                  ctrl_en;
    logic                  ctrl_irq_en;
    logic                  ctrl_oneshot;
    logic                  status_ovf;
    logic [31:0]           period;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic [PRESC_BITS-1:0] prescale;
    logic [PRESC_BITS-1:0] presc_cnt;

    logic                  wr_ctrl;
    logic                  wr_status_clr;
    logic                  wr_period;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_prescale;
    logic                  tick;
    logic                  wrap;
    logic [31:0]           rd_mux;

    // Replace only the byte lanes whose strobe is set; the other lanes keep
    // the register's current contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Write decode and timer events. CTRL and STATUS live entirely in byte 0,
    // so a write there only takes effect when byte 0 is enabled; a CTRL write
    // without byte 0 therefore does not override a one-shot EN clear.
    always_comb begin
        wr_ctrl       = wr_en && (wr_addr == ADDR_CTRL) && wr_strb[0];
        wr_status_clr = wr_en && (wr_addr == ADDR_STATUS) && wr_strb[0] && wr_data[0];
        wr_period     = wr_en && (wr_addr == ADDR_PERIOD);
        wr_count      = wr_en && (wr_addr == ADDR_COUNT);
        wr_compare    = wr_en && (wr_addr == ADDR_COMPARE);
        wr_prescale   = wr_en && (wr_addr == ADDR_PRESCALE);
        tick          = ctrl_en && (presc_cnt == prescale);
        wrap          = tick && (count == period);
    end

    // Read mux over the current register values, so a read that coincides
    // with a write to the same register returns the pre-write contents.
    always_comb begin
        rd_mux = 32'h0;
        case (rd_addr)
            ADDR_CTRL:     rd_mux = {29'h0, ctrl_oneshot, ctrl_irq_en, ctrl_en};
            ADDR_STATUS:   rd_mux = {31'h0, status_ovf};
            ADDR_PERIOD:   rd_mux = period;
            ADDR_COUNT:    rd_mux = count;
            ADDR_COMPARE:  rd_mux = compare;
            ADDR_PRESCALE: rd_mux = 32'(prescale);
            default:       rd_mux = 32'h0;
        endcase
    end

    // Control bits. A bus write to CTRL wins over the one-shot clear of EN
    // that happens when the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en      <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            ctrl_oneshot <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en      <= wr_data[0];
            ctrl_irq_en  <= wr_data[1];
            ctrl_oneshot <= wr_data[2];
        end else if (wrap && ctrl_oneshot) begin
            ctrl_en      <= 1'b0;
        end
    end

    // Overflow flag. A hardware set in the same cycle as a W1C keeps the
    // flag high so that no overflow event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_ovf <= 1'b0;
        end else if (wrap) begin
            status_ovf <= 1'b1;
        end else if (wr_status_clr) begin
            status_ovf <= 1'b0;
        end
    end

    // Plain byte-maskable configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period   <= PERIOD_RST;
            compare  <= 32'h0;
            prescale <= '0;
        end else begin
            if (wr_period) begin
                period <= merge_bytes(period, wr_data, wr_strb);
            end
            if (wr_compare) begin
                compare <= merge_bytes(compare, wr_data, wr_strb);
            end
            if (wr_prescale) begin
                prescale <= PRESC_BITS'(merge_bytes(32'(prescale), wr_data, wr_strb));
            end
        end
    end

    // Prescaler and main counter. A bus write to COUNT reloads the counter
    // and restarts the prescaler, taking priority over any tick this cycle.
    // The prescaler only advances while the timer is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
            count     <= 32'h0;
        end else if (wr_count) begin
            presc_cnt <= '0;
            count     <= merge_bytes(count, wr_data, wr_strb);
        end else if (ctrl_en) begin
            if (tick) begin
                presc_cnt <= '0;
                count     <= wrap ? 32'h0 : count + 32'd1;
            end else begin
                presc_cnt <= presc_cnt + PRESC_BITS'(1);
            end
        end
    end

    // Bus handshake. Acks are single-cycle echoes of the strobes; rd_data is
    // only reloaded on a read so it holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            wr_ack <= wr_en;
            rd_ack <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    // Registered outputs, computed from the current register values so they
    // lag the registers by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq     <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            irq     <= status_ovf && ctrl_irq_en;
            pwm_out <= ctrl_en && (count < compare);
        end
    end

endmodule

// File: tb/tb_axi_timer_regs.sv
// tb_axi_timer_regs
// Self-checking bench for axi_timer_regs. A stimulus process drives one bus
// cycle at a time, advances a behavioural model of the timer and pushes the
// expected outputs for the following cycle into a scoreboard queue. A monitor
// process pops one entry per cycle and compares it with the DUT outputs.

module tb_axi_timer_regs;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ack;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        irq;
    logic        pwm_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd_ack;
        logic [31:0] rd_data;
        logic        wr_ack;
        logic        irq;
        logic        pwm;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state: the programmer-visible registers plus the
    // prescaler count and the last value returned on the read bus.
    bit          m_en;
    bit          m_irq_en;
    bit          m_oneshot;
    bit          m_ovf;
    logic [31:0] m_period;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic [15:0] m_prescale;
    logic [15:0] m_pcnt;
    logic [31:0] m_rd_data;

    axi_timer_regs #(
        .PRESC_BITS(16),
        .PERIOD_RST(32'hFFFF_FFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_ack  (wr_ack),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_ack  (rd_ack),
        .irq     (irq),
        .pwm_out (pwm_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane update of a register value.
    function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr)
            4'd0:    return {29'h0, 1'(m_oneshot), 1'(m_irq_en), 1'(m_en)};
            4'd1:    return {31'h0, 1'(m_ovf)};
            4'd2:    return m_period;
            4'd3:    return m_count;
            4'd4:    return m_compare;
            4'd5:    return {16'h0, m_prescale};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_tick_now();
        return m_en && (m_pcnt == m_prescale);
    endfunction

    function automatic bit model_wrap_now();
        return model_tick_now() && (m_count == m_period);
    endfunction

    task automatic model_reset();
        m_en       = 1'b0;
        m_irq_en   = 1'b0;
        m_oneshot  = 1'b0;
        m_ovf      = 1'b0;
        m_period   = 32'hFFFF_FFFF;
        m_count    = 32'h0;
        m_compare  = 32'h0;
        m_prescale = 16'h0;
        m_pcnt     = 16'h0;
        m_rd_data  = 32'h0;
    endtask

    // Advance the model by one clock: timer rules first, then bus writes
    // override where the bus has priority.
    task automatic model_step(input bit do_wr, input logic [3:0] waddr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        bit          tick;
        bit          wrap;
        bit          n_en;
        bit          n_ovf;
        logic [31:0] n_count;
        logic [15:0] n_pcnt;
        logic [31:0] tmp;
        tick    = model_tick_now();
        wrap    = model_wrap_now();
        n_en    = m_en;
        n_ovf   = m_ovf;
        n_count = m_count;
        n_pcnt  = m_pcnt;
        if (m_en) n_pcnt = tick ? 16'h0 : m_pcnt + 16'h1;
        if (tick) n_count = wrap ? 32'h0 : m_count + 32'h1;
        if (wrap && m_oneshot) n_en = 1'b0;
        if (do_wr && waddr == 4'd1 && wstrb[0] && wdata[0]) n_ovf = 1'b0;
        if (wrap) n_ovf = 1'b1;
        if (do_wr) begin
            case (waddr)
                4'd0: if (wstrb[0]) begin
                    n_en      = wdata[0];
                    m_irq_en  = wdata[1];
                    m_oneshot = wdata[2];
                end
                4'd2: m_period  = strobe_merge(m_period, wdata, wstrb);
                4'd3: begin
                    n_count = strobe_merge(m_count, wdata, wstrb);
                    n_pcnt  = 16'h0;
                end
                4'd4: m_compare = strobe_merge(m_compare, wdata, wstrb);
                4'd5: begin
                    tmp        = strobe_merge({16'h0, m_prescale}, wdata, wstrb);
                    m_prescale = tmp[15:0];
                end
                default: ;
            endcase
        end
        m_en    = n_en;
        m_ovf   = n_ovf;
        m_count = n_count;
        m_pcnt  = n_pcnt;
    endtask

    // Drive one bus cycle and queue the outputs expected after the next edge.
    task automatic applyStimulus(input bit do_rst, input bit do_wr,
                                 input logic [3:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input bit do_rd,
                                 input logic [3:0] raddr);
        exp_t e;
        @(negedge clk);
        rst     = do_rst;
        wr_en   = do_wr;
        wr_addr = waddr;
        wr_data = wdata;
        wr_strb = wstrb;
        rd_en   = do_rd;
        rd_addr = raddr;
        if (do_rst) begin
            model_reset();
            e.rd_ack  = 1'b0;
            e.rd_data = 32'h0;
            e.wr_ack  = 1'b0;
            e.irq     = 1'b0;
            e.pwm     = 1'b0;
        end else begin
            if (do_rd) m_rd_data = model_read(raddr);
            e.rd_ack  = do_rd;
            e.rd_data = m_rd_data;
            e.wr_ack  = do_wr;
            e.irq     = m_ovf && m_irq_en;
            e.pwm     = m_en && (m_count < m_compare);
            model_step(do_wr, waddr, wdata, wstrb);
        end
        exp_q.push_back(e);
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, addr, data, 4'hF, 1'b0, 4'h0);
    endtask

    task automatic busRead(input logic [3:0] addr);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("rd_ack", {31'h0, rd_ack}, {31'h0, e.rd_ack});
            checkOutput("rd_data", rd_data, e.rd_data);
            checkOutput("wr_ack", {31'h0, wr_ack}, {31'h0, e.wr_ack});
            checkOutput("irq", {31'h0, irq}, {31'h0, e.irq});
            checkOutput("pwm_out", {31'h0, pwm_out}, {31'h0, e.pwm});
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          found;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'h0;
        wr_data = 32'h0;
        wr_strb = 4'h0;
        rd_en   = 1'b0;
        rd_addr = 4'h0;
        model_reset();

        // Reset values across the map.
        doReset();
        for (int a = 0; a < 7; a++) busRead(4'(a));
        idle(1);

        // Partial byte write to PERIOD.
        applyStimulus(1'b0, 1'b1, 4'd2, 32'h1234_5678, 4'b0010, 1'b0, 4'h0);
        busRead(4'd2);
        idle(2);

        // Free-running count with wrap, overflow, interrupt and W1C.
        doReset();
        busWrite(4'd2, 32'd3);
        busWrite(4'd5, 32'd0);
        busWrite(4'd0, 32'h3);
        for (int i = 0; i < 8; i++) busRead(4'd3);
        busRead(4'd1);
        busWrite(4'd0, 32'h2);
        busWrite(4'd1, 32'h1);
        busRead(4'd1);
        idle(3);

        // One-shot with prescaler.
        doReset();
        busWrite(4'd2, 32'd2);
        busWrite(4'd5, 32'd1);
        busWrite(4'd0, 32'h5);
        for (int i = 0; i < 10; i++) busRead(4'd3);
        busRead(4'd0);
        busRead(4'd1);
        busRead(4'd3);

        // PWM duty and COMPARE=0.
        doReset();
        busWrite(4'd2, 32'd9);
        busWrite(4'd4, 32'd3);
        busWrite(4'd0, 32'h1);
        idle(25);
        busWrite(4'd4, 32'd0);
        idle(12);
        busWrite(4'd4, 32'd20);
        idle(12);

        // W1C in the overflow cycle must leave OVF set.
        doReset();
        busWrite(4'd2, 32'd3);
        busWrite(4'd0, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (model_wrap_now()) begin
                applyStimulus(1'b0, 1'b1, 4'd1, 32'h1, 4'h1, 1'b1, 4'd1);
                found = 1'b1;
            end else begin
                busRead(4'd3);
            end
        end
        busRead(4'd1);
        idle(2);

        // COUNT write on a tick cycle wins over the increment.
        busWrite(4'd5, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (model_tick_now()) begin
                busWrite(4'd3, 32'd7);
                found = 1'b0;
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        busRead(4'd3);

        // Reset during strobes: no acks.
        applyStimulus(1'b1, 1'b1, 4'd2, 32'h5, 4'hF, 1'b1, 4'd2);
        busRead(4'd2);

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'd3, 32'h0, 4'hF, 1'($urandom_range(0, 1)), 4'd0);
            end else begin
                waddr = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
                case (waddr)
                    4'd0: begin
                        wdata = $urandom;
                        wdata[0] = ($urandom_range(0, 4) != 0);
                    end
                    4'd2: wdata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
                    4'd3: wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
                    4'd4: wdata = 32'($urandom_range(0, 14));
                    4'd5: wdata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 2));
                    default: wdata = $urandom;
                endcase
                wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                applyStimulus(1'b0, ($urandom_range(0, 99) < 30), waddr, wdata, wstrb,
                              1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            end
        end
        idle(3);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
